// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg : loader state encodings and default sizing. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
    localparam logic [63:0] DEFAULT_BASE_ADDR   = 64'h0;
    localparam int          DEFAULT_CNT_W       = 16;
    localparam int          HDR_W               = 16;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
// ----------------------------------------------------------------------------
// imem_loader_byte_assembler : little-endian byte-to-word packer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_loader_byte_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    // Bytes enter at the top and shift down, so b0 ends up in bits [7:0].
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr_i) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[31:8]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = accept_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, shift_q[31:8]};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader : boot-time instruction memory writer with core reset hold. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [63:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          CNT_W       = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [7:0]       s_byte,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             imem_we,
    output logic [63:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         hdr_lo_q, hdr_lo_d;
    logic               we_q, we_d;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               w_asm_clr;
    logic               w_accept_data;
    logic               w_word_valid;
    logic [31:0]        w_word;
    logic [HDR_W-1:0]   w_hdr_cnt;
    logic               w_start_ok;

    assign s_ready       = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
    assign w_accept_data = s_valid && (state_q == ST_DATA);
    assign w_hdr_cnt     = {s_byte, hdr_lo_q};
    assign w_start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

    imem_loader_byte_assembler u_asm (
        .clk_i        (CLK),
        .rst_ni       (RST),
        .clr_i        (w_asm_clr),
        .accept_i     (w_accept_data),
        .byte_i       (s_byte),
        .word_valid_o (w_word_valid),
        .word_o       (w_word)
    );

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        count_d   = count_q;
        hdr_lo_d  = hdr_lo_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        w_asm_clr = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_start_ok) begin
                    state_d   = ST_HDR0;
                    words_d   = '0;
                    w_asm_clr = 1'b1;
                end
            end
            ST_HDR0: begin
                if (s_valid) begin
                    hdr_lo_d = s_byte;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (s_valid) begin
                    count_d = CNT_W'(w_hdr_cnt);
                    if (w_hdr_cnt == '0) begin
                        state_d = ST_DONE;
                    end else if (32'(w_hdr_cnt) > 32'(DEPTH_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Address uses the pre-increment count; the strobe and the
                // count update land on the same edge.
                if (w_word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = w_word;
                    addr_d  = BASE_ADDR + {{(62-CNT_W){1'b0}}, words_q, 2'b00};
                    words_d = words_q + CNT_W'(1);
                    if (words_q == count_q - CNT_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            words_q  <= '0;
            count_q  <= '0;
            hdr_lo_q <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= 64'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            words_q  <= words_d;
            count_q  <= count_d;
            hdr_lo_q <= hdr_lo_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign busy         = s_ready || (state_q == ST_FLUSH);
    assign done         = (state_q == ST_DONE);
    assign core_rst_n   = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader : scoreboard bench for imem_loader (two base addresses). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        CLK;
    logic        RST;
    logic        start_a, start_b;
    logic [7:0]  s_byte;
    logic        s_valid;

    logic        s_ready_a, imem_we_a, core_rst_n_a, busy_a, done_a, err_a;
    logic [63:0] imem_addr_a;
    logic [31:0] imem_wdata_a;
    logic [15:0] words_a;
    logic        s_ready_b, imem_we_b, core_rst_n_b, busy_b, done_b, err_b;
    logic [63:0] imem_addr_b;
    logic [31:0] imem_wdata_b;
    logic [15:0] words_b;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t exp_q[$];
    wr_t obs_a[$];
    wr_t obs_b[$];

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(64'h0), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .s_byte(s_byte), .s_valid(s_valid),
        .s_ready(s_ready_a), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
        .imem_wdata(imem_wdata_a), .core_rst_n(core_rst_n_a), .busy(busy_a),
        .done(done_a), .err(err_a), .words_loaded(words_a)
    );

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(64'h100), .CNT_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .s_byte(s_byte), .s_valid(s_valid),
        .s_ready(s_ready_b), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
        .imem_wdata(imem_wdata_b), .core_rst_n(core_rst_n_b), .busy(busy_b),
        .done(done_b), .err(err_b), .words_loaded(words_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (imem_we_a) obs_a.push_back({imem_addr_a, imem_wdata_a});
        if (imem_we_b) obs_b.push_back({imem_addr_b, imem_wdata_b});
    endtask

    task automatic pulse_start(input bit which_b);
        if (which_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Independent model: header gives N, every complete group of 4 data bytes is one write.
    task automatic push_expected(input bq_t img, input logic [63:0] base);
        int n;
        n = int'({img[1], img[0]});
        for (int k = 0; k < n && (4*k + 5) < img.size(); k++) begin
            exp_q.push_back({base + 64'(4*k),
                             {img[4*k+5], img[4*k+4], img[4*k+3], img[4*k+2]}});
        end
    endtask

    task automatic send_bytes(input bq_t img, input bit gapped, output bit ok);
        bit acc;
        ok = 1'b1;
        foreach (img[i]) begin
            acc = 1'b0;
            for (int t = 0; t < 64 && !acc; t++) begin
                s_byte  = img[i];
                s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
                acc     = s_valid && (s_ready_a || s_ready_b);
                tick();
            end
            s_valid = 1'b0;
            if (!acc) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0; s_byte = 8'h00;
        tick(); tick();
        n_checks++;
        if ({s_ready_a, imem_we_a, core_rst_n_a, busy_a, done_a, err_a} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {s_ready_a, imem_we_a, core_rst_n_a, busy_a, done_a, err_a});
        end
        n_checks++;
        if ({imem_addr_a, imem_wdata_a, words_a} !== 112'd0) begin
            n_errors++;
            $display("FAIL reset_regs: got addr %h data %h words %0d expected zeros",
                     imem_addr_a, imem_wdata_a, words_a);
        end
        RST = 1'b1;
        tick(); tick();
    endtask

    task automatic test_basic();
        bq_t img;
        bit  ok;
        wr_t e, o;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        push_expected(img, 64'h0);
        pulse_start(1'b0);
        n_checks++;
        if ({busy_a, s_ready_a, core_rst_n_a} !== 3'b110) begin
            n_errors++;
            $display("FAIL basic_started: got busy/ready/crst %b expected 110",
                     {busy_a, s_ready_a, core_rst_n_a});
        end
        send_bytes(img, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL basic_timeout: got stall expected accept"); end
        n_checks++;
        if ({done_a, core_rst_n_a} !== 2'b00) begin
            n_errors++;
            $display("FAIL basic_done_early: got %b expected 00", {done_a, core_rst_n_a});
        end
        tick();
        n_checks++;
        if ({done_a, core_rst_n_a, busy_a, words_a} !== {3'b110, 16'd2}) begin
            n_errors++;
            $display("FAIL basic_done: got done %b crst %b busy %b words %0d expected 1 1 0 2",
                     done_a, core_rst_n_a, busy_a, words_a);
        end
        n_checks++;
        if (obs_a.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL basic_write_count: got %0d expected %0d", obs_a.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_a.size() > 0) begin
            e = exp_q.pop_front(); o = obs_a.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL basic_write: got addr %h data %h expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_a.delete();
    endtask

    task automatic test_gapped();
        bq_t img, one;
        bit  ok;
        wr_t e, o;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        push_expected(img, 64'h0);
        pulse_start(1'b0);
        foreach (img[i]) begin
            one = '{img[i]};
            send_bytes(one, 1'b1, ok);
            if (!ok) begin
                n_checks++; n_errors++;
                $display("FAIL gapped_timeout: got stall at byte %0d expected accept", i);
                break;
            end
            if (i == 4) begin
                n_checks++;
                if (obs_a.size() != 0) begin
                    n_errors++;
                    $display("FAIL gapped_early_write: got %0d writes expected 0", obs_a.size());
                end
            end
            if (i >= 2 && i < img.size() - 1) begin
                n_checks++;
                if (s_ready_a !== 1'b1) begin
                    n_errors++;
                    $display("FAIL gapped_ready: got %b expected 1 at byte %0d", s_ready_a, i);
                end
            end
        end
        tick();
        n_checks++;
        if ({done_a, words_a} !== {1'b1, 16'd2}) begin
            n_errors++;
            $display("FAIL gapped_done: got done %b words %0d expected 1 2", done_a, words_a);
        end
        n_checks++;
        if (obs_a.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL gapped_write_count: got %0d expected %0d", obs_a.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_a.size() > 0) begin
            e = exp_q.pop_front(); o = obs_a.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL gapped_write: got addr %h data %h expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_a.delete();
    endtask

    task automatic test_zero_and_overflow();
        bq_t img;
        bit  ok;
        img = '{8'h00, 8'h00};
        pulse_start(1'b0);
        send_bytes(img, 1'b0, ok);
        tick();
        n_checks++;
        if ({ok, done_a, core_rst_n_a, words_a} !== {3'b111, 16'd0} || obs_a.size() != 0) begin
            n_errors++;
            $display("FAIL zero_hdr: got ok %b done %b crst %b words %0d writes %0d expected 1 1 1 0 0",
                     ok, done_a, core_rst_n_a, words_a, obs_a.size());
        end
        img = '{8'h01, 8'h01};
        pulse_start(1'b0);
        send_bytes(img, 1'b0, ok);
        s_valid = 1'b1;
        tick(); tick(); tick();
        s_valid = 1'b0;
        n_checks++;
        if ({ok, err_a, s_ready_a, core_rst_n_a, busy_a} !== 5'b11000 || dut_a.state_q !== ST_ERR) begin
            n_errors++;
            $display("FAIL overflow_hdr: got ok %b err %b rdy %b crst %b busy %b state %0d expected 1 1 0 0 0 %0d",
                     ok, err_a, s_ready_a, core_rst_n_a, busy_a, dut_a.state_q, ST_ERR);
        end
        n_checks++;
        if (obs_a.size() != 0) begin
            n_errors++;
            $display("FAIL overflow_writes: got %0d expected 0", obs_a.size());
        end
        pulse_start(1'b0);
        n_checks++;
        if ({err_a, busy_a, s_ready_a} !== 3'b011) begin
            n_errors++;
            $display("FAIL err_clear: got err %b busy %b rdy %b expected 0 1 1", err_a, busy_a, s_ready_a);
        end
        img = '{8'h00, 8'h00};
        send_bytes(img, 1'b0, ok);
        tick();
        obs_a.delete();
    endtask

    task automatic test_reset_mid();
        bq_t img;
        bit  ok;
        wr_t e, o;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
        push_expected(img, 64'h0);
        pulse_start(1'b0);
        send_bytes(img, 1'b0, ok);
        #3 RST = 1'b0;
        #2;
        n_checks++;
        if ({s_ready_a, imem_we_a, core_rst_n_a, busy_a, done_a, err_a} !== 6'b0 ||
            {imem_addr_a, imem_wdata_a, words_a} !== 112'd0 || dut_a.u_asm.cnt_q !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got rdy %b we %b busy %b addr %h data %h words %0d cnt %0d expected zeros",
                     s_ready_a, imem_we_a, busy_a, imem_addr_a, imem_wdata_a, words_a, dut_a.u_asm.cnt_q);
        end
        tick(); tick();
        RST = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (!ok || obs_a.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL reset_mid_write_count: got %0d expected %0d", obs_a.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_a.size() > 0) begin
            e = exp_q.pop_front(); o = obs_a.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reset_mid_write: got addr %h data %h expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_a.delete();
    endtask

    task automatic test_reload();
        bq_t img;
        bit  ok1, ok2;
        wr_t e, o;
        img = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        push_expected(img, 64'h100);
        pulse_start(1'b1);
        send_bytes(img, 1'b0, ok1);
        tick();
        n_checks++;
        if ({done_b, core_rst_n_b} !== 2'b11) begin
            n_errors++;
            $display("FAIL reload_first_done: got %b expected 11", {done_b, core_rst_n_b});
        end
        push_expected(img, 64'h100);
        pulse_start(1'b1);
        n_checks++;
        if ({core_rst_n_b, done_b, busy_b, words_b} !== {3'b001, 16'd0}) begin
            n_errors++;
            $display("FAIL reload_crst_drop: got crst %b done %b busy %b words %0d expected 0 0 1 0",
                     core_rst_n_b, done_b, busy_b, words_b);
        end
        send_bytes(img, 1'b0, ok2);
        tick();
        n_checks++;
        if ({ok1, ok2, done_b, core_rst_n_b, words_b} !== {4'b1111, 16'd1}) begin
            n_errors++;
            $display("FAIL reload_done: got ok %b%b done %b crst %b words %0d expected 11 1 1 1",
                     ok1, ok2, done_b, core_rst_n_b, words_b);
        end
        n_checks++;
        if (obs_b.size() !== exp_q.size() || obs_a.size() != 0) begin
            n_errors++;
            $display("FAIL reload_write_count: got %0d (other %0d) expected %0d",
                     obs_b.size(), obs_a.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_b.size() > 0) begin
            e = exp_q.pop_front(); o = obs_b.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL reload_write: got addr %h data %h expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_b.delete();
    endtask

    task automatic test_start_in_data();
        bq_t img, head, tail;
        bit  ok1, ok2;
        wr_t e, o;
        img  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        head = img[0:3];
        tail = img[4:9];
        push_expected(img, 64'h0);
        pulse_start(1'b0);
        send_bytes(head, 1'b0, ok1);
        pulse_start(1'b0);
        n_checks++;
        if (dut_a.u_asm.cnt_q !== 2'd2 || words_a !== 16'd0 || {busy_a, s_ready_a} !== 2'b11 ||
            dut_a.state_q !== ST_DATA) begin
            n_errors++;
            $display("FAIL start_in_data: got cnt %0d words %0d busy %b rdy %b state %0d expected 2 0 1 1 %0d",
                     dut_a.u_asm.cnt_q, words_a, busy_a, s_ready_a, dut_a.state_q, ST_DATA);
        end
        send_bytes(tail, 1'b0, ok2);
        tick();
        n_checks++;
        if ({ok1, ok2, done_a, words_a} !== {3'b111, 16'd2}) begin
            n_errors++;
            $display("FAIL start_in_data_done: got ok %b%b done %b words %0d expected 11 1 2",
                     ok1, ok2, done_a, words_a);
        end
        n_checks++;
        if (obs_a.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL start_in_data_write_count: got %0d expected %0d", obs_a.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_a.size() > 0) begin
            e = exp_q.pop_front(); o = obs_a.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL start_in_data_write: got addr %h data %h expected addr %h data %h",
                         o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_a.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_zero_and_overflow();
        test_reset_mid();
        test_reload();
        test_start_in_data();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle core's instruction memory. The core's fetch path is the reader of that memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to instruction memory at consecutive word-aligned addresses.
- Holds the core in reset until the program image is fully written, then releases it.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 64'h0, byte address of the first instruction written.
- CNT_W, 16, width of the word-count header and of words_loaded.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load session. Honoured only in IDLE, DONE or ERR.
- s_byte  in  8  stream data byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  64  byte address of the write, always word-aligned.
- imem_wdata  out  32  instruction word, {b3,b2,b1,b0}.
- core_rst_n  out  1  active-low reset to the processor.
- busy  out  1  load session in progress.
- done  out  1  image fully written; core released.
- err  out  1  header word count exceeds DEPTH_WORDS.
- words_loaded  out  CNT_W  number of words written this session.

Behaviour:
- Reset (RST=0, async): state IDLE. s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, words_loaded=0, byte counter=0.
- A byte is accepted only on a cycle with s_valid=1 and s_ready=1.
- s_ready is 1 exactly in states HDR0, HDR1 and DATA. No backpressure inside DATA.
- States and transitions:
  - IDLE: start -> HDR0. Also clears words_loaded, byte counter and err.
  - HDR0: accept count[7:0] -> HDR1.
  - HDR1: accept count[15:8]. Then:
    - N=0 -> DONE, no writes.
    - N>DEPTH_WORDS -> ERR.
    - otherwise -> DATA.
  - DATA: 2-bit byte counter wraps 3->0.
    - On acceptance of the 4th byte of a word, next cycle: imem_we=1, imem_wdata = assembled word, imem_addr = BASE_ADDR + 4*words_loaded (pre-increment value). words_loaded increments at the same edge as the strobe.
    - If that word is word N, state -> FLUSH at the same edge.
  - FLUSH: one cycle; imem_we=0 -> DONE.
  - DONE: done=1, core_rst_n=1, busy=0. start -> HDR0 with counters cleared; core_rst_n returns to 0 on the cycle after start.
  - ERR: err=1, core_rst_n=0, s_ready=0. start -> HDR0 with err cleared.
- busy=1 in HDR0, HDR1, DATA and FLUSH.
- core_rst_n=0 in every state except DONE.
- Output timing:
  - imem_we is a registered single-cycle pulse.
  - Minimum spacing between strobes is 4 cycles.
  - done and core_rst_n rise exactly 2 cycles after the final byte is accepted.
- start while busy is ignored.
- s_valid outside HDR0/HDR1/DATA is ignored; no byte is consumed.
- Reset mid-load: immediate return to IDLE, core_rst_n=0, partial word discarded. Memory contents already written are not rolled back.
- words_loaded saturates by construction at N ≤ DEPTH_WORDS. Address arithmetic is 64-bit and does not wrap within DEPTH.

Decomposition:
- Shared constants header, included by loader and bench: state encodings (IDLE, HDR0, HDR1, DATA, FLUSH, DONE, ERR) and the default DEPTH_WORDS/BASE_ADDR.
- Sub-module byte_assembler: 2-bit counter plus 32-bit little-endian shift register. Outputs word_valid on the 4th byte and supports a clear input.
- FSM, address generation and core-reset control stay in imem_loader.

Test Plan:
- Basic load: reset, start, bytes 02 00 13 05 A0 00 93 05 B0 00, s_valid held high.
  - Two imem_we pulses: addr 0 data 00A00513, then addr 4 data 00B00593.
  - done=1 and core_rst_n=1 two cycles after the last byte; words_loaded=2.
- Gapped stream: same image with s_valid toggled randomly.
  - Identical writes; no write until 4 bytes are accepted.
  - s_ready stays 1 throughout DATA.
- Zero and overflow headers:
  - Header 00 00 -> DONE with no imem_we.
  - Header 01 01 (257) with DEPTH_WORDS=256 -> err=1, s_ready=0, core_rst_n=0.
  - Subsequent start clears err.
- Reset mid-word: RST low after 2 data bytes of word 1 -> all outputs at reset values asynchronously; no write for the partial word.
- Reload: in DONE, start then 1-word image 6F 00 00 00 with BASE_ADDR=64'h100.
  - core_rst_n drops the next cycle.
  - Write at addr 0x100 data 0000006F; core released again.
- start pulsed during DATA: ignored; byte counter and words_loaded unaffected.
